// File: rtl/test_reader.sv
// Consumer end of the receive read interface: pops packets, checks them
// against an incrementing expected sequence and counts good/bad packets.
module test_reader #(
  parameter int unsigned             PACKET_WIDTH = 32,
  parameter int unsigned             CNT_W        = 16,
  parameter logic [PACKET_WIDTH-1:0] SEED         = '0,
  parameter int unsigned             TARGET       = 0,
  parameter int unsigned             PACED        = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    clear,
  input  logic                    tick,
  input  logic                    input_buffer_empty,
  input  logic [PACKET_WIDTH-1:0] packet_in,
  output logic                    read_req,
  output logic [PACKET_WIDTH-1:0] packet_out,
  output logic                    packet_out_valid,
  output logic                    mismatch,
  output logic [CNT_W-1:0]        rx_count,
  output logic [CNT_W-1:0]        err_count,
  output logic                    done
);

  typedef enum logic [1:0] {IDLE, REQ, CAP, CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TARGET_CNT = CNT_W'(TARGET);
  localparam bit               HAS_TARGET = (TARGET != 0);
  localparam bit               IS_PACED   = (PACED != 0);

  state_t                  state, state_d;
  logic [PACKET_WIDTH-1:0] expected, expected_d;
  logic [PACKET_WIDTH-1:0] packet_out_d;
  logic [CNT_W-1:0]        rx_d, err_d;
  logic                    read_req_d, valid_d, mismatch_d, done_d;
  logic                    clear_pend, clear_pend_d;

  logic                    hit;
  logic                    start_ok;
  logic [CNT_W-1:0]        rx_inc, err_inc;

  // Data compare, start condition and saturating increments
  assign hit      = (packet_in == expected);
  assign start_ok = enable && !input_buffer_empty && !done && (tick || !IS_PACED);
  assign rx_inc   = (rx_count  == CNT_MAX) ? rx_count  : rx_count  + CNT_W'(1);
  assign err_inc  = (err_count == CNT_MAX) ? err_count : err_count + CNT_W'(1);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      expected         <= SEED;
      clear_pend       <= 1'b0;
      read_req         <= 1'b0;
      packet_out       <= '0;
      packet_out_valid <= 1'b0;
      mismatch         <= 1'b0;
      rx_count         <= '0;
      err_count        <= '0;
      done             <= 1'b0;
    end else begin
      state            <= state_d;
      expected         <= expected_d;
      clear_pend       <= clear_pend_d;
      read_req         <= read_req_d;
      packet_out       <= packet_out_d;
      packet_out_valid <= valid_d;
      mismatch         <= mismatch_d;
      rx_count         <= rx_d;
      err_count        <= err_d;
      done             <= done_d;
    end
  end

  // Next state and next output values; the check result is registered so
  // it appears together with packet_out during CHK
  always_comb begin
    state_d      = state;
    expected_d   = expected;
    clear_pend_d = clear_pend | clear;
    read_req_d   = 1'b0;
    packet_out_d = packet_out;
    valid_d      = 1'b0;
    mismatch_d   = 1'b0;
    rx_d         = rx_count;
    err_d        = err_count;
    done_d       = done;

    case (state)
      IDLE: begin
        clear_pend_d = 1'b0;
        if (clear) begin
          rx_d       = '0;
          err_d      = '0;
          done_d     = 1'b0;
          expected_d = SEED;
        end else if (start_ok) begin
          state_d    = REQ;
          read_req_d = 1'b1;
        end
      end
      REQ: begin
        state_d = CAP;
      end
      CAP: begin
        state_d      = CHK;
        packet_out_d = packet_in;
        valid_d      = 1'b1;
        mismatch_d   = !hit;
        expected_d   = packet_in + PACKET_WIDTH'(1);
        // A pending clear means this packet is checked but not counted
        if (!clear_pend_d) begin
          rx_d = rx_inc;
          if (!hit) begin
            err_d = err_inc;
          end
          if (HAS_TARGET && (rx_inc == TARGET_CNT)) begin
            done_d = 1'b1;
          end
        end
      end
      CHK: begin
        state_d = IDLE;
        if (clear_pend_d) begin
          rx_d         = '0;
          err_d        = '0;
          done_d       = 1'b0;
          expected_d   = SEED;
          clear_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_test_reader.sv
// Self-checking bench for test_reader: three instances (free-running,
// paced with a wrapping seed, and with a done target) fed by simple
// receive-buffer models and checked against a sequence model.
module tb_test_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, en, clr, tick, emp;
  logic [2:0]  rr, pov, mis, dn;
  logic [31:0] pin [3];
  logic [31:0] po  [3];
  logic [15:0] rxc [3];
  logic [15:0] erc [3];

  // Receive buffer models: words pushed by the stimulus, popped on read_req,
  // read data presented the cycle after read_req
  logic [31:0] mem [3][64];
  logic [5:0]  wp  [3];
  logic [5:0]  rp  [3] = '{default: 6'd0};

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rr[i]) begin
        pin[i] <= mem[i][rp[i]];
        rp[i]  <= rp[i] + 6'd1;
      end
    end
  end

  assign emp[0] = (wp[0] == rp[0]);
  assign emp[1] = (wp[1] == rp[1]);
  assign emp[2] = (wp[2] == rp[2]);

  test_reader #(.PACKET_WIDTH(32), .CNT_W(16), .SEED(32'h0), .TARGET(0), .PACED(0)) u_a (
    .clk(clk), .rst(rst[0]), .enable(en[0]), .clear(clr[0]), .tick(tick[0]),
    .input_buffer_empty(emp[0]), .packet_in(pin[0]), .read_req(rr[0]),
    .packet_out(po[0]), .packet_out_valid(pov[0]), .mismatch(mis[0]),
    .rx_count(rxc[0]), .err_count(erc[0]), .done(dn[0]));

  test_reader #(.PACKET_WIDTH(32), .CNT_W(16), .SEED(32'hFFFF_FFFE), .TARGET(0), .PACED(1)) u_b (
    .clk(clk), .rst(rst[1]), .enable(en[1]), .clear(clr[1]), .tick(tick[1]),
    .input_buffer_empty(emp[1]), .packet_in(pin[1]), .read_req(rr[1]),
    .packet_out(po[1]), .packet_out_valid(pov[1]), .mismatch(mis[1]),
    .rx_count(rxc[1]), .err_count(erc[1]), .done(dn[1]));

  test_reader #(.PACKET_WIDTH(32), .CNT_W(16), .SEED(32'h0), .TARGET(2), .PACED(0)) u_c (
    .clk(clk), .rst(rst[2]), .enable(en[2]), .clear(clr[2]), .tick(tick[2]),
    .input_buffer_empty(emp[2]), .packet_in(pin[2]), .read_req(rr[2]),
    .packet_out(po[2]), .packet_out_valid(pov[2]), .mismatch(mis[2]),
    .rx_count(rxc[2]), .err_count(erc[2]), .done(dn[2]));

  // Reference model state per instance
  logic [31:0] seed_of [3] = '{32'h0, 32'hFFFF_FFFE, 32'h0};
  int          tgt     [3] = '{0, 0, 2};
  logic [31:0] mexp    [3];
  logic [15:0] mrx     [3];
  logic [15:0] merr    [3];
  logic        mdone   [3];
  logic [5:0]  mr      [3];
  int          nrr     [3];
  int          nmis    [3];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int i);
    mexp[i]  = seed_of[i];
    mrx[i]   = 16'd0;
    merr[i]  = 16'd0;
    mdone[i] = 1'b0;
  endtask

  task automatic push(input int i, input logic [31:0] v);
    mem[i][wp[i]] = v;
    wp[i] = wp[i] + 6'd1;
  endtask

  task automatic check_zero(input int i);
    chk($sformatf("u%0d rst read_req", i), 64'(rr[i]), 64'd0);
    chk($sformatf("u%0d rst valid", i), 64'(pov[i]), 64'd0);
    chk($sformatf("u%0d rst mismatch", i), 64'(mis[i]), 64'd0);
    chk($sformatf("u%0d rst packet_out", i), 64'(po[i]), 64'd0);
    chk($sformatf("u%0d rst rx_count", i), 64'(rxc[i]), 64'd0);
    chk($sformatf("u%0d rst err_count", i), 64'(erc[i]), 64'd0);
    chk($sformatf("u%0d rst done", i), 64'(dn[i]), 64'd0);
  endtask

  task automatic check_counts(input int i, input string tag);
    chk({tag, " rx_count"}, 64'(rxc[i]), 64'(mrx[i]));
    chk({tag, " err_count"}, 64'(erc[i]), 64'(merr[i]));
    chk({tag, " done"}, 64'(dn[i]), 64'(mdone[i]));
  endtask

  // Runs instance i until n packets are seen (or the whole budget if n==0),
  // checking every packet against the model and read_req timing.
  task automatic run(input int i, input int n, input int budget,
                     input int tick_period, input bit exact4);
    int          cyc = 0;
    int          got = 0;
    int          last_rr = -1;
    int          last_tick = -100;
    logic [31:0] word;
    bit          bad;
    while (cyc < budget && (n == 0 || got < n)) begin
      @(negedge clk);
      cyc++;
      if (rr[i]) begin
        nrr[i]++;
        if (tick_period > 0)
          chk($sformatf("u%0d rr after tick", i), 64'(cyc - last_tick), 64'd1);
        else if (last_rr >= 0 && exact4)
          chk($sformatf("u%0d rr spacing", i), 64'(cyc - last_rr), 64'd4);
        else if (last_rr >= 0)
          chk($sformatf("u%0d rr spacing>=4", i), 64'(cyc - last_rr >= 4), 64'd1);
        last_rr = cyc;
      end
      if (pov[i]) begin
        word = mem[i][mr[i]];
        mr[i] = mr[i] + 6'd1;
        bad = (word != mexp[i]);
        if (mrx[i] != 16'hFFFF) mrx[i] = mrx[i] + 16'd1;
        if (bad && merr[i] != 16'hFFFF) merr[i] = merr[i] + 16'd1;
        if (tgt[i] != 0 && int'(mrx[i]) == tgt[i]) mdone[i] = 1'b1;
        mexp[i] = word + 32'd1;
        if (bad) nmis[i]++;
        got++;
        chk($sformatf("u%0d pkt data", i), 64'(po[i]), 64'(word));
        chk($sformatf("u%0d pkt mismatch", i), 64'(mis[i]), 64'(bad));
        check_counts(i, $sformatf("u%0d pkt", i));
      end else begin
        chk($sformatf("u%0d idle mismatch", i), 64'(mis[i]), 64'd0);
      end
      tick[i] = (tick_period > 0) && (cyc % tick_period == 0);
      if (tick[i]) last_tick = cyc;
    end
    tick[i] = 1'b0;
    chk($sformatf("u%0d packets seen", i), 64'(got), 64'(n));
  endtask

  task automatic clear_pulse(input int i);
    @(negedge clk);
    clr[i] = 1'b1;
    @(negedge clk);
    clr[i] = 1'b0;
    model_reset(i);
    check_counts(i, $sformatf("u%0d after clear", i));
  endtask

  initial begin
    int          r0;
    int          waited;
    logic [31:0] gen;
    logic [31:0] w;

    rst = 3'b000; en = 3'b000; clr = 3'b000; tick = 3'b000;
    for (int i = 0; i < 3; i++) begin
      wp[i] = 6'd0; mr[i] = 6'd0; nrr[i] = 0; nmis[i] = 0;
      model_reset(i);
    end

    // Reset state
    #12;
    for (int i = 0; i < 3; i++) check_zero(i);
    repeat (2) @(negedge clk);
    rst = 3'b111;

    // Basic: back-to-back reads of an incrementing sequence
    for (int k = 0; k < 4; k++) push(0, 32'(k));
    en[0] = 1'b1;
    run(0, 4, 40, 0, 1'b1);
    chk("basic read_req count", 64'(nrr[0]), 64'd4);
    chk("basic mismatches", 64'(nmis[0]), 64'd0);
    chk("basic rx_count", 64'(rxc[0]), 64'd4);
    repeat (3) @(negedge clk);

    // Mismatch and resync: only the 7 is bad, 8 passes
    clear_pulse(0);
    push(0, 32'd0); push(0, 32'd1); push(0, 32'd7); push(0, 32'd8);
    run(0, 4, 40, 0, 1'b1);
    chk("resync mismatches", 64'(nmis[0]), 64'd1);
    chk("resync err_count", 64'(erc[0]), 64'd1);
    chk("resync rx_count", 64'(rxc[0]), 64'd4);

    // Paced reads with a wrapping expected value
    push(1, 32'hFFFF_FFFE); push(1, 32'hFFFF_FFFF); push(1, 32'h0);
    en[1] = 1'b1;
    run(1, 3, 60, 10, 1'b0);
    chk("wrap read_req count", 64'(nrr[1]), 64'd3);
    chk("wrap err_count", 64'(erc[1]), 64'd0);
    chk("wrap rx_count", 64'(rxc[1]), 64'd3);
    // Ticks while the buffer is empty start nothing
    run(1, 0, 50, 10, 1'b0);
    chk("empty read_req count", 64'(nrr[1]), 64'd3);

    // Done at target, reads blocked until clear
    for (int k = 0; k < 5; k++) push(2, 32'(k));
    en[2] = 1'b1;
    run(2, 2, 30, 0, 1'b1);
    chk("done high", 64'(dn[2]), 64'd1);
    run(2, 0, 30, 0, 1'b1);
    chk("done blocks reads", 64'(nrr[2]), 64'd2);
    clear_pulse(2);
    run(2, 2, 30, 0, 1'b1);
    chk("after clear read_req count", 64'(nrr[2]), 64'd4);
    chk("after clear mismatches", 64'(nmis[2]), 64'd1);

    // Asynchronous reset while a read is in flight
    repeat (3) @(negedge clk);
    push(0, 32'd9); push(0, 32'd10);
    waited = 0;
    while (!rr[0] && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("reset test read_req seen", 64'(rr[0]), 64'd1);
    @(posedge clk);
    #2;
    rst[0] = 1'b0;
    #1;
    check_zero(0);
    @(negedge clk);
    rst[0] = 1'b1;
    mr[0] = rp[0];
    model_reset(0);
    run(0, 1, 20, 0, 1'b0);
    chk("post reset err_count", 64'(erc[0]), 64'd1);

    // Randomized mix of in-sequence and stray words
    repeat (3) @(negedge clk);
    clear_pulse(0);
    gen = 32'd0;
    r0 = nmis[0];
    for (int k = 0; k < 20; k++) begin
      if ($urandom_range(3) == 0) w = $urandom;
      else w = gen;
      gen = w + 32'd1;
      push(0, w);
    end
    run(0, 20, 200, 0, 1'b1);
    check_counts(0, "random final");
    chk("random err vs mismatches", 64'(erc[0]), 64'(nmis[0] - r0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/test_reader.md
Name: test_reader

Overview:
- Consumer end of the test_receive read interface: drains packets from the receive buffer using read_req and input_buffer_empty.
- Checks each packet against an expected incrementing sequence, and counts good and bad packets.
- Sits after receive1 in the loopback test top, closing the send→receive→read path so a bench or SoC can self-check the link.

Parameters:
PACKET_WIDTH, 32, packet and sequence width in bits
CNT_W, 16, width of rx_count and err_count
SEED, 0, expected value of the first packet after reset or clear
TARGET, 0, rx_count value at which done asserts; 0 = never done
PACED, 1, 1 = start a read only on a tick; 0 = read whenever data is available

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
enable  in  1  permits new reads; level-sensitive
clear  in  1  synchronous pulse; zeroes counters, reloads expected with SEED
tick  in  1  pacing strobe, one cycle wide
input_buffer_empty  in  1  receive buffer empty flag
packet_in  in  PACKET_WIDTH  receive buffer read data
read_req  out  1  one-cycle read strobe to the receive buffer
packet_out  out  PACKET_WIDTH  last packet read
packet_out_valid  out  1  one-cycle pulse when packet_out updates
mismatch  out  1  one-cycle pulse, coincident with packet_out_valid, when packet != expected
rx_count  out  CNT_W  packets read, saturating
err_count  out  CNT_W  mismatched packets, saturating
done  out  1  sticky; high once rx_count == TARGET (TARGET != 0)

Behaviour:
- Reset (rst=0, async): all outputs 0; expected = SEED; FSM in IDLE.
- Reset mid-read drops the outstanding read. The buffer word already popped is lost, which is acceptable.
- FSM states: IDLE, REQ, CAP, CHK.
- IDLE → REQ when enable & !input_buffer_empty & !done & (tick | !PACED), all sampled at the same edge.
- REQ: read_req=1 for exactly one cycle → CAP.
- CAP: the buffer presents data one cycle after read_req. Register packet_in into packet_out → CHK.
- CHK: packet_out_valid=1 for one cycle.
  - If packet_out == expected: rx_count++.
  - Else: rx_count++, err_count++, mismatch=1.
  - In both cases expected ← packet_out + 1, modulo 2^PACKET_WIDTH (resync on error).
  - Then → IDLE.
- Throughput: at most one packet per 4 cycles. A tick arriving while not in IDLE is ignored, not queued.
- Expected value wraps 2^PACKET_WIDTH−1 → 0 with no error.
- rx_count and err_count saturate at 2^CNT_W−1; expected keeps updating after saturation.
- enable deasserted in REQ, CAP or CHK: the current read completes; no new read starts.
- input_buffer_empty is sampled only in IDLE. read_req is never asserted while empty was seen high at the IDLE decision.
- done: set in the CHK cycle where rx_count becomes TARGET. Stays high until rst or clear, and blocks further reads.
- clear:
  - In IDLE: zeroes rx_count, err_count and done, and sets expected = SEED at the same edge.
  - In any other state: takes effect at the next IDLE entry; the in-flight packet is still checked against the old expected but not counted.
  - clear and tick in the same IDLE cycle: clear wins; no read starts that cycle.
- packet_out holds its last value between reads.

Test Plan:
- Basic: PACED=0, buffer preloaded with 0,1,2,3, enable=1.
  - Required: read_req pulses at 4-cycle spacing.
  - Required: packet_out_valid ×4, rx_count=4, err_count=0, mismatch never high.
- Mismatch/resync: buffer holds 0,1,7,8.
  - Required: mismatch only on the 7.
  - Required: err_count=1, rx_count=4; 8 passes because expected resynced to 8.
- Wrap: SEED=32'hFFFF_FFFE, buffer holds FFFF_FFFE, FFFF_FFFF, 0.
  - Required: err_count=0, rx_count=3.
- Pacing and empty:
  - PACED=1, 3 words buffered, ticks every 10 cycles: exactly 3 read_req pulses, each 1 cycle after a tick.
  - Further ticks with input_buffer_empty=1: no read_req.
- Done/clear: TARGET=2, 5 words buffered, PACED=0.
  - Required: done rises with the 2nd packet_out_valid; no 3rd read_req.
  - After a clear pulse: done=0, counts=0, reading resumes.
- Async reset: drop rst during CAP.
  - Required: all outputs 0 immediately, without waiting for a clock edge.
  - Required after release: FSM idles; next read checks against SEED.
